exhaustive_stim_capture: RTL and testbench
==========================================

Name: exhaustive_stim_capture

Overview:
- Synthesizable successor to the fixed 3-input exhaustive benches used for trojan detection.
- Walks all 2^N_WIDTH input patterns into a DUT and waits a programmable settle time per pattern.
- Samples the DUT response and emits one (pattern, response) record per pattern on a valid/ready stream to the logger.
- Compacts all responses into a MISR signature, so golden-vs-suspect netlists compare by one word.

Parameters:
- N_WIDTH, 3: DUT input width; 2^N_WIDTH patterns per run (1..16).
- OUT_WIDTH, 1: DUT response width (1..SIG_WIDTH).
- SETTLE_CYCLES, 1: cycles a pattern is held before the response is sampled (1..255).
- SIG_WIDTH, 16: MISR width.
- SIG_POLY, 16'h1021: MISR feedback polynomial (SIG_WIDTH bits).

Ports:
- CK  in  1  clock; all logic on posedge CK.
- reset  in  1  synchronous reset, active-high.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- gray_mode  in  1  0 = ascending binary order, 1 = Gray-code order; latched at start.
- pat  out  N_WIDTH  pattern driven to the DUT inputs.
- resp  in  OUT_WIDTH  DUT response.
- rec_valid  out  1  record available.
- rec_ready  in  1  logger accepts the record.
- rec_pattern  out  N_WIDTH  pattern of the current record.
- rec_response  out  OUT_WIDTH  sampled response of the current record.
- signature  out  SIG_WIDTH  running MISR value.
- busy  out  1  run in progress (SETTLE or EMIT).
- done  out  1  run complete; held until the next start or reset.

Behaviour:
- Reset (synchronous, any state): all outputs 0, index 0, settle counter 0, state IDLE. A run in progress is abandoned; no partial record stays valid.
- States: IDLE, SETTLE, EMIT, DONE.
- IDLE or DONE with start=1:
  - Latch gray_mode, set index=0, clear signature to 0, done=0.
  - Next cycle: pat=map(0), state SETTLE, counter=SETTLE_CYCLES.
- map(i): i in binary mode; i ^ (i>>1) in Gray mode.
- SETTLE:
  - Counter decrements each cycle.
  - In the cycle it reads 1: capture resp into rec_response, copy pat into rec_pattern, assert rec_valid next cycle, go to EMIT.
  - Net effect: each pattern is held exactly SETTLE_CYCLES cycles before sampling.
- EMIT:
  - rec_valid=1; rec_pattern, rec_response and pat stay stable until rec_valid && rec_ready.
  - rec_ready may be low any number of cycles.
- On handshake:
  - rec_valid drops next cycle.
  - Signature update: sig <= (sig<<1) ^ (sig[MSB] ? SIG_POLY : 0) ^ zero_extend(rec_response).
  - If index == 2^N_WIDTH-1: go to DONE, done=1, busy=0. pat holds its last value.
  - Otherwise: index+1, pat=map(index+1), go to SETTLE with counter reloaded.
- Throughput with rec_ready tied high: SETTLE_CYCLES+1 cycles per pattern. The final signature is valid in the same cycle done rises.
- busy=1 in SETTLE and EMIT only.
- start while busy: ignored; no restart, no signature clear.
- start in DONE: restarts the run exactly as from IDLE.
- gray_mode changes mid-run: no effect until the next start.
- Index wrap: the index never wraps; the run terminates at the last pattern. N_WIDTH=1 gives a 2-pattern run.
- signature remains readable in DONE until the next start or reset.

Test Plan:
- Ascending order: N_WIDTH=3, SETTLE_CYCLES=1, DUT model resp=^pat, rec_ready=1, pulse start.
  - Records in order: (000,0) (001,1) (010,1) (011,0) (100,1) (101,0) (110,0) (111,1).
  - Exactly 8 records; done=1; signature=16'h0069; 16 cycles from first SETTLE to done.
- Gray order: same setup with gray_mode=1.
  - Patterns 000,001,011,010,110,111,101,100; responses 0,1,0,1,0,1,0,1.
  - signature=16'h0055.
- Backpressure: hold rec_ready=0 for 5 cycles on the 3rd record.
  - rec_valid stays 1; rec_pattern=010, rec_response and pat stable throughout.
  - No duplicate or lost record; final signature still 16'h0069.
- Settle timing: SETTLE_CYCLES=4, DUT response delayed 3 cycles after pat changes.
  - All 8 records match resp=^pat.
  - Repeat with SETTLE_CYCLES=2: records mismatch, proving sampling time is honoured.
- Reset mid-run: assert reset during the 5th record's EMIT.
  - Next cycle: rec_valid=0, busy=0, done=0, signature=0, pat=000, state IDLE.
  - A fresh start reproduces the ascending-order results exactly.
- Spurious start: pulse start during SETTLE of pattern 2.
  - Run unaffected: 8 records, signature 16'h0069.
  - Then start in DONE: done drops, signature clears, run repeats identically.

Source files
------------

// File: rtl/exhaustive_stim_capture.sv
// Exhaustive pattern walker: drives every N_WIDTH-bit pattern into a DUT,
// waits a settle time, streams (pattern, response) records and folds them into a MISR.
// Ports: CK, reset (sync, active-high), start, gray_mode, pat (to DUT), resp (from DUT),
//        rec_valid/rec_ready/rec_pattern/rec_response (record stream), signature, busy, done.
module exhaustive_stim_capture #(
  parameter int N_WIDTH = 3,
  parameter int OUT_WIDTH = 1,
  parameter int SETTLE_CYCLES = 1,
  parameter int SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY = 16'h1021
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 gray_mode,
  output logic [N_WIDTH-1:0]   pat,
  input  logic [OUT_WIDTH-1:0] resp,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_pattern,
  output logic [OUT_WIDTH-1:0] rec_response,
  output logic [SIG_WIDTH-1:0] signature,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES);

  state_t state;
  state_t state_nx;

  logic [7:0]           cnt;
  logic [N_WIDTH-1:0]   idx;
  logic [N_WIDTH-1:0]   idx_inc;
  logic                 gray_q;
  logic                 hs;
  logic                 last;
  logic                 cnt_one;
  logic [SIG_WIDTH-1:0] sig_nx;

  function automatic logic [N_WIDTH-1:0] map_idx(
    input logic [N_WIDTH-1:0] i,
    input logic               g
  );
    return g ? (i ^ (i >> 1)) : i;
  endfunction

  assign idx_inc = idx + N_WIDTH'(1);
  assign hs      = rec_valid && rec_ready;
  assign last    = (idx == {N_WIDTH{1'b1}});
  assign cnt_one = (cnt == 8'd1);

  assign sig_nx = {signature[SIG_WIDTH-2:0], 1'b0}
                ^ (signature[SIG_WIDTH-1] ? SIG_POLY : '0)
                ^ SIG_WIDTH'(rec_response);

  assign rec_valid = (state == S_EMIT);
  assign busy      = (state == S_SETTLE) || (state == S_EMIT);
  assign done      = (state == S_DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_SETTLE;
      S_SETTLE:       if (cnt_one) state_nx = S_EMIT;
      S_EMIT:         if (hs) state_nx = last ? S_DONE : S_SETTLE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      gray_q       <= 1'b0;
      pat          <= '0;
      rec_pattern  <= '0;
      rec_response <= '0;
      signature    <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            gray_q    <= gray_mode;
            idx       <= '0;
            signature <= '0;
            pat       <= '0;
            cnt       <= CNT_LOAD;
          end
        end
        S_SETTLE: begin
          cnt <= cnt - 8'd1;
          if (cnt_one) begin
            rec_pattern  <= pat;
            rec_response <= resp;
          end
        end
        S_EMIT: begin
          if (hs) begin
            signature <= sig_nx;
            // Last pattern: pat keeps its final value into DONE.
            if (!last) begin
              idx <= idx_inc;
              pat <= map_idx(idx_inc, gray_q);
              cnt <= CNT_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// Scoreboard bench for exhaustive_stim_capture: ordering, backpressure,
// settle timing, mid-run reset, spurious and repeated start.
module tb_exhaustive_stim_capture;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        reset;
  logic        start;
  logic        gray_mode;
  logic [2:0]  pat;
  logic [0:0]  resp;
  logic        rec_valid;
  logic        rec_ready;
  logic [2:0]  rec_pattern;
  logic [0:0]  rec_response;
  logic [15:0] signature;
  logic        busy;
  logic        done;

  assign resp = ^pat;

  exhaustive_stim_capture #(
    .N_WIDTH(3), .OUT_WIDTH(1), .SETTLE_CYCLES(1),
    .SIG_WIDTH(16), .SIG_POLY(16'h1021)
  ) u_dut (
    .CK(ck), .reset(reset), .start(start),
    .gray_mode(gray_mode), .pat(pat), .resp(resp),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_pattern(rec_pattern),
    .rec_response(rec_response),
    .signature(signature), .busy(busy), .done(done)
  );

  // Slow-DUT instances: response lags pat by 3 cycles.
  logic        st2;
  logic        gm0 = 1'b0;
  logic        rdy_hi = 1'b1;
  logic [2:0]  pat4, pat2, rp4, rp2;
  logic [0:0]  rs4, rs2, rr4, rr2;
  logic [8:0]  dl4, dl2;
  logic        rv4, rv2, bz4, bz2, dn4, dn2;
  logic [15:0] sg4, sg2;

  always_ff @(posedge ck) begin
    if (reset) begin
      dl4 <= '0;
      dl2 <= '0;
    end else begin
      dl4 <= {dl4[5:0], pat4};
      dl2 <= {dl2[5:0], pat2};
    end
  end
  assign rs4 = ^dl4[8:6];
  assign rs2 = ^dl2[8:6];

  exhaustive_stim_capture #(
    .N_WIDTH(3), .OUT_WIDTH(1), .SETTLE_CYCLES(4)
  ) u_s4 (
    .CK(ck), .reset(reset), .start(st2),
    .gray_mode(gm0), .pat(pat4), .resp(rs4),
    .rec_valid(rv4), .rec_ready(rdy_hi),
    .rec_pattern(rp4), .rec_response(rr4),
    .signature(sg4), .busy(bz4), .done(dn4)
  );

  exhaustive_stim_capture #(
    .N_WIDTH(3), .OUT_WIDTH(1), .SETTLE_CYCLES(2)
  ) u_s2 (
    .CK(ck), .reset(reset), .start(st2),
    .gray_mode(gm0), .pat(pat2), .resp(rs2),
    .rec_valid(rv2), .rec_ready(rdy_hi),
    .rec_pattern(rp2), .rec_response(rr2),
    .signature(sg2), .busy(bz2), .done(dn2)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] q[$];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  int n4 = 0;
  int mm2 = 0;
  always @(negedge ck) begin
    if (rv4) begin
      chk("s4_pat", 32'(rp4), 32'(n4));
      chk("s4_resp", 32'(rr4), 32'(^rp4));
      n4++;
    end
    if (rv2 && (rr2 != ^rp2)) mm2++;
  end

  task automatic run(
    input bit          g,
    input bit          bp,
    input bit          spur,
    input bit          abort,
    input logic [15:0] exp_sig
  );
    int cyc, recs, stall;
    bit sp_done;
    logic [2:0] p;
    logic [3:0] e;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      p = 3'(i);
      if (g) p = p ^ (p >> 1);
      q.push_back({^p, p});
    end
    @(negedge ck);
    gray_mode = g;
    start = 1'b1;
    rec_ready = 1'b1;
    @(negedge ck);
    start = 1'b0;
    gray_mode = ~g;
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(done), 0);
    chk("start_sig", 32'(signature), 0);
    cyc = 0;
    recs = 0;
    stall = 0;
    sp_done = 0;
    while (!done && cyc < 200) begin
      rec_ready = 1'b1;
      start = 1'b0;
      if (spur && !sp_done && recs == 2
          && !rec_valid) begin
        start = 1'b1;
        sp_done = 1;
      end
      if (abort && recs == 4 && rec_valid) begin
        reset = 1'b1;
        @(negedge ck);
        reset = 1'b0;
        chk("rst_valid", 32'(rec_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sig", 32'(signature), 0);
        chk("rst_pat", 32'(pat), 0);
        q.delete();
        return;
      end
      if (rec_valid) begin
        if (bp && recs == 2 && stall < 5) begin
          rec_ready = 1'b0;
          chk("bp_rpat", 32'(rec_pattern), 2);
          chk("bp_pat", 32'(pat), 2);
          chk("bp_resp", 32'(rec_response), 1);
          stall++;
        end else if (q.size() == 0) begin
          chk("extra_rec", 32'(recs), 8);
          recs++;
        end else begin
          e = q.pop_front();
          chk("rec_pat", 32'(rec_pattern), 32'(e[2:0]));
          chk("rec_resp", 32'(rec_response), 32'(e[3]));
          recs++;
        end
      end else if (bp && recs == 2
                   && stall > 0 && stall < 5) begin
        chk("bp_valid", 32'(rec_valid), 1);
      end
      @(negedge ck);
      cyc++;
    end
    start = 1'b0;
    chk("done", 32'(done), 1);
    chk("busy_end", 32'(busy), 0);
    chk("sig", 32'(signature), 32'(exp_sig));
    chk("recs", 32'(recs), 8);
    chk("q_empty", 32'(q.size()), 0);
    chk("cycles", 32'(cyc), bp ? 21 : 16);
    chk("pat_hold", 32'(pat), g ? 4 : 7);
  endtask

  initial begin
    int w;
    reset = 1'b1;
    start = 1'b0;
    gray_mode = 1'b0;
    rec_ready = 1'b1;
    st2 = 1'b0;
    repeat (3) @(negedge ck);
    reset = 1'b0;
    @(negedge ck);
    chk("rst0_valid", 32'(rec_valid), 0);
    chk("rst0_busy", 32'(busy), 0);
    chk("rst0_done", 32'(done), 0);
    chk("rst0_sig", 32'(signature), 0);
    chk("rst0_pat", 32'(pat), 0);

    run(1'b0, 1'b0, 1'b0, 1'b0, 16'h0069);
    run(1'b1, 1'b0, 1'b0, 1'b0, 16'h0055);
    run(1'b0, 1'b1, 1'b0, 1'b0, 16'h0069);
    run(1'b0, 1'b0, 1'b0, 1'b1, 16'h0069);
    run(1'b0, 1'b0, 1'b0, 1'b0, 16'h0069);
    run(1'b0, 1'b0, 1'b1, 1'b0, 16'h0069);
    run(1'b0, 1'b0, 1'b0, 1'b0, 16'h0069);

    @(negedge ck);
    st2 = 1'b1;
    @(negedge ck);
    st2 = 1'b0;
    w = 0;
    while (!(dn4 && dn2) && w < 400) begin
      @(negedge ck);
      w++;
    end
    chk("s4_done", 32'(dn4), 1);
    chk("s2_done", 32'(dn2), 1);
    chk("s4_count", 32'(n4), 8);
    chk("s2_mismatch", 32'(mm2 > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
